// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_pkg
// Brief    : Shared width defaults and stage-count helper for the adder.
// Revision : 1.0
// ============================================================================
package pipelined_adder_pkg;

  localparam int c_DEFAULT_WIDTH = 32;
  localparam int c_DEFAULT_CHUNK = 8;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_if
// Brief    : Operand/result handshake bundle between producer and adder.
// Revision : 1.0
// ============================================================================
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             carryIn;
  logic             sub;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
  logic             overflow;
  logic             outValid;
  logic             outReady;

  modport master (
    output in1, in2, carryIn, sub, inValid, outReady,
    input  inReady, sum, carryOut, overflow, outValid
  );

  modport slave (
    input  in1, in2, carryIn, sub, inValid, outReady,
    output inReady, sum, carryOut, overflow, outValid
  );

endinterface
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : One-bit full adder cell.
// Revision : 1.0
// ============================================================================
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_sum  = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule
`default_nettype wire

// File: rtl/pipelined_adder_slice.sv
`default_nettype none
// ============================================================================
// Module   : adder_slice
// Brief    : CHUNK-bit combinational ripple adder built from full_adder cells.
// Revision : 1.0
// ============================================================================
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < CHUNK; k++) begin : g_bit
    full_adder u_fa (
      .i_a    (i_a[k]),
      .i_b    (i_b[k]),
      .i_cin  (w_c[k]),
      .o_sum  (o_sum[k]),
      .o_cout (w_c[k+1])
    );
  end

  assign o_cout = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Brief    : Chunked add/subtract pipeline with skew/deskew and global stall.
// Revision : 1.0
// ============================================================================
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH,
  parameter int CHUNK = c_DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  pipelined_adder_if.slave bus
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  logic              w_stall;
  logic              w_en;
  logic [WIDTH-1:0]  w_b_in;
  logic              w_cin;
  logic [WIDTH-1:0]  w_sum;
  logic [STAGES-1:0] w_cy;
  logic              w_ovf;
  logic [STAGES-1:0] r_vld;
  logic              r_ov;

  assign w_stall = r_vld[STAGES-1] & ~bus.outReady;
  assign w_en    = ~w_stall;
  // Subtraction is in1 + ~in2 + 1, so the incoming carry is forced high.
  assign w_b_in  = bus.sub ? ~bus.in2 : bus.in2;
  assign w_cin   = bus.sub | bus.carryIn;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_ov  <= 1'b0;
    end else if (w_en) begin
      r_vld[0] <= bus.inValid;
      for (int i = 1; i < STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
      r_ov <= w_ovf;
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_chunk
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_s;
    logic             w_ci;
    logic             w_co;
    logic             w_cm;
    logic             r_co;
    logic [CHUNK-1:0] r_sd [0:STAGES-1-j];

    if (j == 0) begin : g_direct
      assign w_a  = bus.in1[CHUNK-1:0];
      assign w_b  = w_b_in[CHUNK-1:0];
      assign w_ci = w_cin;
    end else begin : g_skew
      // Chunk j is delayed j cycles so it meets the carry from slice j-1.
      logic [CHUNK-1:0] r_ad [0:j-1];
      logic [CHUNK-1:0] r_bd [0:j-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < j; i++) begin
            r_ad[i] <= '0;
            r_bd[i] <= '0;
          end
        end else if (w_en) begin
          r_ad[0] <= bus.in1[j*CHUNK +: CHUNK];
          r_bd[0] <= w_b_in[j*CHUNK +: CHUNK];
          for (int i = 1; i < j; i++) begin
            r_ad[i] <= r_ad[i-1];
            r_bd[i] <= r_bd[i-1];
          end
        end
      end

      assign w_a  = r_ad[j-1];
      assign w_b  = r_bd[j-1];
      assign w_ci = w_cy[j-1];
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a    (w_a),
      .i_b    (w_b),
      .i_cin  (w_ci),
      .o_sum  (w_s),
      .o_cout (w_co),
      .o_cmsb (w_cm)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        r_co <= 1'b0;
        for (int i = 0; i <= STAGES-1-j; i++) begin
          r_sd[i] <= '0;
        end
      end else if (w_en) begin
        r_co    <= w_co;
        r_sd[0] <= w_s;
        for (int i = 1; i <= STAGES-1-j; i++) begin
          r_sd[i] <= r_sd[i-1];
        end
      end
    end

    assign w_cy[j]                = r_co;
    assign w_sum[j*CHUNK +: CHUNK] = r_sd[STAGES-1-j];

    if (j == STAGES-1) begin : g_msb
      assign w_ovf = w_co ^ w_cm;
    end else begin : g_mid
      logic w_cm_unused;
      assign w_cm_unused = w_cm;
    end
  end

  assign bus.inReady  = ~w_stall;
  assign bus.sum      = w_sum;
  assign bus.carryOut = w_cy[STAGES-1];
  assign bus.overflow = r_ov;
  assign bus.outValid = r_vld[STAGES-1];

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have parameter: CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in1  input  WIDTH  operand A.
REQ-006 SHALL have port: in2  input  WIDTH  operand B.
REQ-007 SHALL have port: carryIn  input  1  carry into bit 0.
REQ-008 SHALL have port: sub  input  1  0 = add, 1 = subtract (in1 - in2).
REQ-009 SHALL have port: inValid  input  1  operands valid this cycle.
REQ-010 SHALL have port: inReady  output  1  block accepts operands this cycle.
REQ-011 SHALL have port: sum  output  WIDTH  result.
REQ-012 SHALL have port: carryOut  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-013 SHALL have port: overflow  output  1  signed (two's-complement) overflow.
REQ-014 SHALL have port: outValid  output  1  sum/carryOut/overflow valid.
REQ-015 SHALL have port: outReady  input  1  consumer accepts result.

Function
REQ-016 SHALL compute in1 + in2 + carryIn when sub=0; in1 + ~in2 + 1 when sub=1 (carryIn ignored).
REQ-017 SHALL split the add into STAGES ripple slices; stage k adds chunk k plus carry registered from stage k-1.
REQ-018 SHALL register upper operand chunks (skew) and lower result chunks (deskew) so all fields of one transaction emerge together.
REQ-019 SHALL have latency exactly STAGES cycles from accepted input (inValid & inReady) to outValid when unstalled.
REQ-020 SHALL sustain one transaction per cycle when outReady stays high.
REQ-021 SHALL stall globally: stall = outValid & ~outReady; when stalled, every stage register holds.
REQ-022 SHALL drive inReady = ~stall (combinational).
REQ-023 SHALL hold sum/carryOut/overflow/outValid stable while stalled.
REQ-024 SHALL insert bubbles (valid=0) for cycles with inValid=0; bubbles never raise outValid.
REQ-025 SHALL set overflow = carry into MSB XOR carry out of MSB.
REQ-026 SHALL preserve transaction order; none lost, none duplicated.
REQ-027 SHALL require WIDTH to be a multiple of CHUNK and CHUNK >= 1; STAGES = 1 yields a 1-cycle registered adder.

Reset
REQ-028 SHALL, when reset is high at a clock edge, clear all stage valid bits, outValid, sum, carryOut and overflow to 0.
REQ-029 SHALL discard in-flight transactions on reset mid-operation; no stale result appears after release.
REQ-030 SHALL drive inReady = 1 during and after reset (no stall possible, outValid = 0).

Structure
REQ-031 SHALL place default WIDTH/CHUNK and a STAGES derivation function in the shared arithmetic package.
REQ-032 SHALL use one sub-module adder_slice: CHUNK-bit combinational ripple adder built from the existing full_adder cells, outputs sum chunk, carry out and carry into its MSB.

Verification (WIDTH=32, CHUNK=8, latency 4)
REQ-033 SHALL check 0xFFFFFFFF + 0x00000001, carryIn=0 -> sum 0x00000000, carryOut 1, overflow 0, outValid exactly 4 cycles after accept.
REQ-034 SHALL check sub=1, 5 - 7 -> sum 0xFFFFFFFE, carryOut 0, overflow 0; 0x7FFFFFFF + 1 -> 0x80000000, overflow 1, carryOut 0.
REQ-035 SHALL check 0x00FFFFFF + 0x00000001, carryIn=1 -> 0x01000001 (carry crosses three slices).
REQ-036 SHALL check 8 back-to-back inputs with outReady low for 3 cycles mid-stream -> inReady low those cycles, 8 correct results in order, outputs stable while stalled.
REQ-037 SHALL check reset pulse with 3 transactions in flight -> outValid 0 next edge, no result from those 3 ever appears, next input returns correctly after 4 cycles.
